// File: rtl/mp64_pkg.sv
// rtl/mp64_pkg.sv - shared state encodings and width helpers for the mp64 memory arbiter
package mp64_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_RESP  = 2'd2
  } arb_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic int id_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/mp64_rr_pick.sv
// rtl/mp64_rr_pick.sv - rotate-priority encoder: first set mask bit above rr_ptr, with wrap
module mp64_rr_pick #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic [N_REQ-1:0] mask,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic [ID_W-1:0]  win_id,
  output logic             found
);

  logic [N_REQ-1:0] rot;

  always_comb begin
    // rot[j] is requester (rr_ptr+1+j) mod N_REQ, so bit 0 has highest priority
    rot    = N_REQ'({mask, mask} >> (int'(rr_ptr) + 1));
    found  = |rot;
    win_id = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) win_id = ID_W'((int'(rr_ptr) + 1 + i) % N_REQ);
    end
  end

endmodule

// File: rtl/mp64_memarb.sv
// rtl/mp64_memarb.sv - round-robin single-beat arbiter with short bus lock for the CPU memory port
module mp64_memarb
  import mp64_pkg::*;
#(
  parameter int  N_REQ    = 4,
  parameter int  LOCK_MAX = 4,
  localparam int ID_W     = id_width(N_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*32-1:0] req_addr,
  input  logic [N_REQ*64-1:0] req_wdata,
  input  logic [N_REQ-1:0]    req_wen,
  output logic [N_REQ-1:0]    rsp_ack,
  output logic [63:0]         rsp_rdata,
  output logic                mem_req,
  output logic [31:0]         mem_addr,
  output logic [63:0]         mem_wdata,
  output logic                mem_wen,
  input  logic [63:0]         mem_rdata,
  input  logic                mem_ack,
  output logic [ID_W-1:0]     grant_id,
  output logic                busy
);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]  grant_id_q, grant_id_d;
  logic [ID_W-1:0]  lock_owner_q, lock_owner_d;
  logic             lock_held_q, lock_held_d;
  logic             lock_req_q, lock_req_d;
  logic [3:0]       lock_cnt_q, lock_cnt_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [63:0]      mem_wdata_q, mem_wdata_d;
  logic             mem_wen_q, mem_wen_d;
  logic [63:0]      rsp_rdata_q, rsp_rdata_d;
  logic [N_REQ-1:0] rsp_ack_q, rsp_ack_d;

  logic             owner_dropped;
  logic [ID_W-1:0]  pick_ptr;
  logic [N_REQ-1:0] eligible;
  logic [ID_W-1:0]  win_id;
  logic             found;

  always_comb begin
    owner_dropped = lock_held_q & ~req_valid[lock_owner_q];
    // A dropped owner releases at once and becomes lowest priority for this very pick
    pick_ptr      = owner_dropped ? lock_owner_q : rr_ptr_q;
    eligible      = req_valid;
    if (lock_held_q && !owner_dropped) eligible = req_valid & (N_REQ'(1) << lock_owner_q);
  end

  mp64_rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .mask   (eligible),
    .rr_ptr (pick_ptr),
    .win_id (win_id),
    .found  (found)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_id_d   = grant_id_q;
    lock_owner_d = lock_owner_q;
    lock_held_d  = lock_held_q;
    lock_req_d   = lock_req_q;
    lock_cnt_d   = lock_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wen_d    = mem_wen_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_ack_d    = '0;

    case (state_q)
      ARB_IDLE: begin
        if (owner_dropped) begin
          lock_held_d = 1'b0;
          lock_cnt_d  = 4'd0;
          rr_ptr_d    = lock_owner_q;
        end
        if (found) begin
          grant_id_d = win_id;
          state_d    = ARB_ISSUE;
          for (int i = 0; i < N_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
              mem_addr_d  = req_addr[i*32 +: 32];
              mem_wdata_d = req_wdata[i*64 +: 64];
              mem_wen_d   = req_wen[i];
              lock_req_d  = req_lock[i];
            end
          end
        end
      end
      ARB_ISSUE: begin
        if (mem_ack) begin
          rsp_rdata_d = mem_rdata;
          rsp_ack_d   = N_REQ'(1) << grant_id_q;
          state_d     = ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (lock_req_q && (int'(lock_cnt_q) + 1 < LOCK_MAX)) begin
          lock_held_d  = 1'b1;
          lock_owner_d = grant_id_q;
          lock_cnt_d   = lock_cnt_q + 4'd1;
        end else begin
          lock_held_d = 1'b0;
          lock_cnt_d  = 4'd0;
          rr_ptr_d    = grant_id_q;
        end
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      rr_ptr_q     <= ID_W'(N_REQ - 1);
      grant_id_q   <= '0;
      lock_owner_q <= '0;
      lock_held_q  <= 1'b0;
      lock_req_q   <= 1'b0;
      lock_cnt_q   <= 4'd0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wen_q    <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_ack_q    <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_id_q   <= grant_id_d;
      lock_owner_q <= lock_owner_d;
      lock_held_q  <= lock_held_d;
      lock_req_q   <= lock_req_d;
      lock_cnt_q   <= lock_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wen_q    <= mem_wen_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_ack_q    <= rsp_ack_d;
    end
  end

  // Dropping the request in the ack cycle keeps the downstream from seeing a repeat
  assign mem_req   = (state_q == ARB_ISSUE) & ~mem_ack;
  assign busy      = (state_q != ARB_IDLE);
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wen   = mem_wen_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_ack   = rsp_ack_q;
  assign grant_id  = grant_id_q;

endmodule
